// File: rtl/debug_ctrl.sv
// Debug/run controller between the MicroBlaze GPIO frames and the MIPS pipeline.
// Define DEBUG_BREAKPOINT_EN to build the PC breakpoint compare used by RUN.
module debug_ctrl #(
  parameter int NB_FRAME    = 32,
  parameter int NB_REG      = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_STEP     = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_FRAME-1:0]    i_frame_from_blaze,
  output logic [NB_FRAME-1:0]    o_frame_to_blaze,
  output logic                   o_pipe_enable,
  output logic                   o_pipe_reset,
  output logic [NB_REG_ADDR-1:0] o_dbg_reg_addr,
  input  logic [NB_REG-1:0]      i_dbg_reg_data,
  input  logic [NB_REG-1:0]      i_pc,
  input  logic                   i_halt,
  output logic                   o_running
);

  typedef enum logic [1:0] {
    HALTED   = 2'b00,
    RUNNING  = 2'b01,
    STEPPING = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_PIPE_RESET  = 3'd1,
    OP_RUN         = 3'd2,
    OP_STEP        = 3'd3,
    OP_STOP        = 3'd4,
    OP_READ_REG    = 3'd5,
    OP_READ_PC     = 3'd6,
    OP_READ_CYCLES = 3'd7
  } op_t;

  state_t                 state_q, state_d;
  logic [NB_FRAME-1:0]    frame_q;
  logic                   last_req, ack_q, err_q, bp_hit_q;
  logic                   rd_pend_q, rd_hi_q;
  op_t                    op, rd_op_q;
  logic [NB_STEP-1:0]     step_cnt_q, step_load;
  logic [NB_REG-1:0]      cycle_cnt_q, rd_word;
  logic [15:0]            data_q;
  logic                   pipe_enable_q, pipe_reset_q;
  logic [NB_REG_ADDR-1:0] reg_addr_q;
  logic                   cmd_valid, is_read, cmd_err, step_expire, bp_match;
  logic                   unused_frame;

  assign op          = op_t'(frame_q[30:28]);
  // A read in flight blocks acceptance until its data has been captured.
  assign cmd_valid   = (frame_q[NB_FRAME-1] != last_req) && !rd_pend_q;
  assign is_read     = (op == OP_READ_REG) || (op == OP_READ_PC) || (op == OP_READ_CYCLES);
  assign cmd_err     = ((op == OP_RUN) || (op == OP_STEP)) && (state_q != HALTED);
  assign step_expire = (state_q == STEPPING) && (step_cnt_q <= NB_STEP'(1));
  assign step_load   = (frame_q[NB_STEP-1:0] == '0) ? NB_STEP'(1) : frame_q[NB_STEP-1:0];
  assign unused_frame = ^frame_q[27:16];

`ifdef DEBUG_BREAKPOINT_EN
  logic        bp_en_q;
  logic [15:0] bp_addr_q;

  assign bp_match = (state_q == RUNNING) && bp_en_q && (i_pc[17:2] == bp_addr_q);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      bp_hit_q  <= 1'b0;
    end else if (cmd_valid && (op == OP_PIPE_RESET)) begin
      bp_hit_q  <= 1'b0;
    end else if (cmd_valid && (op == OP_RUN) && (state_q == HALTED)) begin
      bp_en_q   <= frame_q[16];
      bp_addr_q <= frame_q[15:0];
      bp_hit_q  <= 1'b0;
    end else if (bp_match) begin
      bp_hit_q  <= 1'b1;
    end
  end
`else
  assign bp_match = 1'b0;
  assign bp_hit_q = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    state_d = state_q;
    if (state_q != HALTED) begin
      if (i_halt || step_expire || bp_match) state_d = HALTED;
    end
    if (cmd_valid) begin
      case (op)
        OP_PIPE_RESET, OP_STOP: state_d = HALTED;
        OP_RUN:  if (state_q == HALTED) state_d = RUNNING;
        OP_STEP: if (state_q == HALTED) state_d = STEPPING;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = cycle_cnt_q;
    case (rd_op_q)
      OP_READ_REG: rd_word = i_dbg_reg_data;
      OP_READ_PC:  rd_word = i_pc;
      default:     ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= HALTED;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_reset) begin
      frame_q       <= '0;
      last_req      <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_hi_q       <= 1'b0;
      rd_op_q       <= OP_NOP;
      step_cnt_q    <= '0;
      cycle_cnt_q   <= '0;
      data_q        <= '0;
      pipe_enable_q <= 1'b0;
      pipe_reset_q  <= 1'b0;
      reg_addr_q    <= '0;
    end else begin
      frame_q       <= i_frame_from_blaze;
      pipe_enable_q <= (state_d != HALTED);
      pipe_reset_q  <= cmd_valid && (op == OP_PIPE_RESET);

      if (cmd_valid) begin
        last_req <= frame_q[NB_FRAME-1];
        err_q    <= cmd_err;
        if (is_read) begin
          rd_pend_q <= 1'b1;
          rd_op_q   <= op;
          rd_hi_q   <= frame_q[5];
        end else begin
          ack_q <= ~ack_q;
        end
        if (op == OP_READ_REG) reg_addr_q <= frame_q[NB_REG_ADDR-1:0];
      end

      if (rd_pend_q) begin
        data_q    <= rd_hi_q ? rd_word[NB_REG-1:16] : rd_word[15:0];
        ack_q     <= ~ack_q;
        rd_pend_q <= 1'b0;
      end

      if (cmd_valid && (op == OP_PIPE_RESET)) cycle_cnt_q <= '0;
      else if (pipe_enable_q)                 cycle_cnt_q <= cycle_cnt_q + 1'b1;

      if (cmd_valid && (op == OP_PIPE_RESET))
        step_cnt_q <= '0;
      else if (cmd_valid && (op == OP_STEP) && (state_q == HALTED))
        step_cnt_q <= step_load;
      else if ((state_q == STEPPING) && (step_cnt_q != '0))
        step_cnt_q <= step_cnt_q - 1'b1;
    end
  end

  assign o_frame_to_blaze = {ack_q, state_q, bp_hit_q, err_q, 11'b0, data_q};
  assign o_pipe_enable    = pipe_enable_q;
  assign o_pipe_reset     = pipe_reset_q;
  assign o_dbg_reg_addr   = reg_addr_q;
  assign o_running        = (state_q != HALTED);

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench for debug_ctrl: directed scenarios plus random commands against an edge-level model.
module tb_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] frame_in;
  logic [31:0] frame_out;
  logic        pipe_enable, pipe_reset, running, halt;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, pc;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  assign reg_data = regs[reg_addr];

  debug_ctrl dut (
    .i_clock            (clk),
    .i_reset            (rst_n),
    .i_frame_from_blaze (frame_in),
    .o_frame_to_blaze   (frame_out),
    .o_pipe_enable      (pipe_enable),
    .o_pipe_reset       (pipe_reset),
    .o_dbg_reg_addr     (reg_addr),
    .i_dbg_reg_data     (reg_data),
    .i_pc               (pc),
    .i_halt             (halt),
    .o_running          (running)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state 0=halted 1=running 2=stepping, steps left, counters and flags.
  int          m_state, m_steps, en_seen;
  bit          m_ack, m_err, m_bp, m_prst;
  logic [31:0] m_cycles;
  logic [15:0] m_data;
  logic [4:0]  m_addr;
`ifdef DEBUG_BREAKPOINT_EN
  bit          m_bp_en;
  logic [15:0] m_bp_addr;
`endif
  bit          req;
  logic [2:0]  cur_op;
  logic [27:0] cur_pl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_steps = 0; m_ack = 0; m_err = 0; m_bp = 0; m_prst = 0;
    m_cycles = '0; m_data = '0; m_addr = '0;
`ifdef DEBUG_BREAKPOINT_EN
    m_bp_en = 0; m_bp_addr = '0;
`endif
  endtask

  // ev: 0 = no command event, 1 = command accepted, 2 = read data captured.
  task automatic model_edge(input int ev);
    int nxt;
    logic [31:0] w;
    nxt = m_state;
    m_prst = 0;
    if (ev == 2) begin
      case (cur_op)
        3'd5:    w = regs[m_addr];
        3'd6:    w = pc;
        default: w = m_cycles;
      endcase
      m_data = cur_pl[5] ? w[31:16] : w[15:0];
      m_ack  = ~m_ack;
    end
    if (m_state != 0) begin
      m_cycles = m_cycles + 1;
      if (m_state == 2) begin
        m_steps--;
        if (m_steps == 0) nxt = 0;
      end
      if (halt) nxt = 0;
`ifdef DEBUG_BREAKPOINT_EN
      if (m_state == 1 && m_bp_en && pc[17:2] == m_bp_addr) begin
        nxt = 0;
        m_bp = 1;
      end
`endif
    end
    if (ev == 1) begin
      m_err = 0;
      if (cur_op < 3'd5) m_ack = ~m_ack;
      case (cur_op)
        3'd1: begin m_cycles = '0; m_steps = 0; m_bp = 0; m_prst = 1; nxt = 0; end
        3'd2: if (m_state == 0) begin
                nxt = 1; m_bp = 0;
`ifdef DEBUG_BREAKPOINT_EN
                m_bp_en = cur_pl[16]; m_bp_addr = cur_pl[15:0];
`endif
              end else m_err = 1;
        3'd3: if (m_state == 0) begin
                nxt = 2;
                m_steps = (cur_pl[15:0] == 16'd0) ? 1 : int'(cur_pl[15:0]);
              end else m_err = 1;
        3'd4: nxt = 0;
        3'd5: m_addr = cur_pl[4:0];
        default: ;
      endcase
    end
    m_state = nxt;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_frame;
    logic [31:0] exp_ctl;
    exp_frame = {m_ack, 2'(m_state), m_bp, m_err, 11'b0, m_data};
    exp_ctl   = {24'b0, (m_state != 0), (m_state != 0), m_prst, m_addr};
    check({tag, "_frame"}, frame_out, exp_frame);
    check({tag, "_ctl"}, {24'b0, pipe_enable, running, pipe_reset, reg_addr}, exp_ctl);
  endtask

  task automatic tick(input int ev);
    @(posedge clk);
    model_edge(ev);
    @(negedge clk);
    if (pipe_enable) en_seen++;
    check_outputs("cycle");
    if (m_state != 0) pc = pc + 32'd4;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0);
  endtask

  task automatic send(input logic [2:0] op, input logic [27:0] pl);
    cur_op = op;
    cur_pl = pl;
    req = ~req;
    frame_in = {req, op, pl};
    tick(0);
    tick(1);
    if (op >= 3'd5) tick(2);
  endtask

  task automatic pulse_halt();
    halt = 1'b1;
    tick(0);
    halt = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [27:0] pl;
    frame_in = '0; halt = 1'b0; pc = '0; req = 1'b0; en_seen = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[3] = 32'hDEADBEEF;
    model_reset();

    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // NOP toggle 0->1: ack one cycle after capture, state halted, no error.
    send(3'd0, 28'($urandom));
    check("nop_ack", 32'(frame_out[31:27]), 32'b10000);

    // PIPE_RESET then STEP 5: exactly five enabled cycles, counter reads 5.
    send(3'd1, 28'd0);
    en_seen = 0;
    send(3'd3, 28'd5);
    check("step5_state", 32'(frame_out[30:29]), 32'd2);
    idle(8);
    check("step5_enables", 32'(en_seen), 32'd5);
    send(3'd7, 28'd0);
    check("step5_cycles", 32'(frame_out[15:0]), 32'h0005);

    // STEP 0 acts as a single step.
    en_seen = 0;
    send(3'd3, 28'd0);
    idle(4);
    check("step0_enables", 32'(en_seen), 32'd1);

    // RUN, RUN again while running gives err, STOP halts.
    send(3'd2, 28'd0);
    idle(20);
    send(3'd2, 28'd0);
    check("run_err", 32'(frame_out[30:27]), 32'b0101);
    send(3'd4, 28'd0);
    check("stop_state", 32'(frame_out[30:27]), 32'b0000);

    // Register read, both halves.
    send(3'd5, 28'h03);
    check("reg_lo", 32'(frame_out[15:0]), 32'hBEEF);
    send(3'd5, 28'h23);
    check("reg_hi", 32'(frame_out[15:0]), 32'hDEAD);

    // i_halt during RUN, counter frozen afterwards.
    send(3'd2, 28'd0);
    idle(5);
    pulse_halt();
    check("halt_state", 32'(frame_out[30:29]), 32'd0);
    idle(5);
    send(3'd7, 28'd0);
    send(3'd7, 28'h20);

    // Asynchronous reset in the middle of a run.
    send(3'd2, 28'd0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    req = 1'b0;
    frame_in = '0;
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // RUN with breakpoint payload at word address 4.
    send(3'd1, 28'd0);
    pc = '0;
    send(3'd2, 28'h1_0004);
    idle(8);
`ifdef DEBUG_BREAKPOINT_EN
    check("bp_halt", 32'(frame_out[30:28]), 32'b001);
    send(3'd6, 28'd0);
    check("bp_pc", 32'(frame_out[15:0]), 32'h0010);
`else
    check("no_bp", 32'(frame_out[30:28]), 32'b010);
    send(3'd4, 28'd0);
`endif

    // Random command mix against the model.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      pl = 28'($urandom);
      if (op == 3'd3) pl[15:0] = 16'($urandom_range(0, 10));
      send(op, pl);
      if ($urandom_range(0, 3) == 0) pulse_halt();
      idle($urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
